// File: rtl/seg_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seg_scan_mux_if
// Bundles the load/display signals of seg_scan_mux.
//   load        : single-cycle strobe capturing digits_in
//   digits_in   : 4*NUM_DIGITS packed digit codes, digit 0 in bits [3:0]
//   dec         : currently scanned digit code (to the 7-segment decoder)
//   an          : one-hot, active-high digit enable
//   frame_done  : one-cycle pulse at the end of each full scan
//   pending     : a loaded value is waiting for the next frame boundary
// Modports: master (drives load/digits_in), slave (the scan mux itself).
// -----------------------------------------------------------------------------
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [3:0]                dec;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output load, digits_in,
    input  dec, an, frame_done, pending
  );

  modport slave (
    input  load, digits_in,
    output dec, an, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexes NUM_DIGITS 4-bit digit codes onto a single decoder input,
// with a one-hot digit enable driven on the same clock edge. New values are
// double-buffered (shadow -> active) and only take effect at a frame boundary.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-high reset
//   bus_if  : seg_scan_mux_if.slave (load, digits_in, dec, an, frame_done,
//             pending)
//
// Parameters:
//   NUM_DIGITS  : digits scanned, 1..8
//   REFRESH_DIV : clock cycles each digit is held, >= 1
//
// Optional build macro:
//   LEAD_ZERO_BLANK_EN : when defined, leading zeros above digit 0 are output
//                        as 4'hF (decoder renders blank); an still asserts.
// -----------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave bus_if
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Index -> one-hot digit enable.
  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Select the 4-bit code of digit idx from a packed value.
  function automatic logic [3:0] pick_digit(input logic [DW-1:0] val,
                                            input logic [IW-1:0] idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) d = val[4*i +: 4];
    end
    return d;
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // Bit i set when digit i (i > 0) and every digit above it are zero.
  // Digit 0 is never blanked so an all-zero value still shows "0".
  function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [DW-1:0] val);
    logic [NUM_DIGITS-1:0] m;
    logic                  above_zero;
    m          = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      above_zero = above_zero & (val[4*i +: 4] == 4'd0);
      m[i]       = above_zero;
    end
    return m;
  endfunction
`endif

  logic [PW-1:0]         prescaler_q, prescaler_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            dec_q, dec_d;
  logic                  tick;
  logic                  frame_end;
`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_d;
`endif

  always_comb begin
    tick      = (prescaler_q == PRE_LAST);
    frame_end = tick && (idx_q == IDX_LAST);

    prescaler_d = tick ? '0 : prescaler_q + PW'(1);

    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    shadow_d = bus_if.load ? bus_if.digits_in : shadow_q;

    // A load on the boundary edge bypasses the shadow straight into active,
    // so nothing is left pending.
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus_if.load)    active_d = bus_if.digits_in;
      else if (pending_q) active_d = shadow_q;
    end else if (bus_if.load) begin
      pending_d = 1'b1;
    end

    frame_done_d = frame_end;

    // Outputs are built from next-state values so an and dec step together
    // and the new frame's digit 0 appears on the boundary edge itself.
    an_d  = onehot(idx_d);
    dec_d = pick_digit(active_d, idx_d);
`ifdef LEAD_ZERO_BLANK_EN
    blank_d = blank_mask(active_d);
    if (|(blank_d & an_d)) dec_d = 4'hF;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '0;
      dec_q        <= 4'd0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      dec_q        <= dec_d;
    end
  end

  assign bus_if.dec        = dec_q;
  assign bus_if.an         = an_q;
  assign bus_if.frame_done = frame_done_q;
  assign bus_if.pending    = pending_q;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Upstream stage of the BCD-to-7-segment decoder in multi-digit displays.
- Holds NUM_DIGITS 4-bit digit codes and time-multiplexes them, one digit at a time, onto the decoder input `dec`.
- Drives a one-hot digit-enable bus `an` in step with `dec`.
- New display values are double-buffered and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles each digit is held; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures digits_in into the shadow register.
- digits_in  in  4*NUM_DIGITS  digit i at bits [4i+3:4i]; digit 0 is rightmost / least significant.
- dec  out  4  current digit code; connects to the decoder's `dec` input.
- an  out  NUM_DIGITS  one-hot, active-high digit enable; bit i selects digit i.
- frame_done  out  1  one-cycle pulse when a full scan completes.
- pending  out  1  a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset (async, immediate on rst rising):
  - prescaler = 0, idx = 0.
  - shadow = 0, active = 0.
  - Outputs: dec = 4'd0, an = 0 (all digits off), frame_done = 0, pending = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, wrapping to 0.
  - `tick` is high when prescaler == REFRESH_DIV-1.
  - REFRESH_DIV = 1 gives tick every cycle.
- Digit index:
  - On tick, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - With NUM_DIGITS = 1, idx stays 0.
- Registered outputs:
  - Every edge outside reset: an <= onehot(idx_next) and dec <= active_next[4*idx_next +: 4].
  - The first edge after reset release gives an = 0...01 and dec = active digit 0.
  - an and dec always change on the same edge (glitch-free).
- Frame boundary = tick while idx == NUM_DIGITS-1. On that edge:
  - frame_done <= 1 for exactly one cycle.
  - If pending: active <= shadow, pending <= 0.
  - dec shows the new active digit 0 on the same edge.
- Load:
  - load = 1 sets shadow <= digits_in and pending <= 1.
  - Multiple loads within one frame: the last one wins.
- Load coinciding with a frame boundary:
  - active <= digits_in directly (bypass), shadow <= digits_in, pending <= 0.
  - The new value is displayed from the next frame's digit 0 onward.
- Digit codes 10..15 pass through unmodified; the decoder blanks them.
- The scan never stalls: load does not reset the prescaler or idx.
- Reset asserted mid-frame aborts the scan. Pending data is discarded; active returns to 0.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: leading-zero blanking.
  - Any digit i > 0 whose value is 0, where all digits above it are also 0, is output as dec = 4'hF, which the decoder renders blank.
  - an still asserts for that digit.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - Blanking is computed from `active` and registered with dec; it adds no latency.
- Undefined: every digit is output as stored. No extra logic is present.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Scan timing after reset release:
   - an steps 0001 -> 0010 -> 0100 -> 1000 -> 0001, each value held 4 cycles.
   - frame_done pulses once every 16 cycles, 1 cycle wide, on the edge where an goes 1000 -> 0001.
2. Load 16'h1234 mid-frame:
   - pending = 1 until the next frame_done, then 0.
   - Next frame shows dec 4, 3, 2, 1 with an 0001, 0010, 0100, 1000.
   - The current frame still shows 0.
3. Load 16'h5678 on the boundary cycle (tick with idx = 3):
   - pending stays 0.
   - The immediately following digit slot shows an = 0001, dec = 8.
4. Loads 16'h1111 then 16'h2222 within one frame:
   - The next frame shows 2, 2, 2, 2; 1111 is never displayed.
5. Assert rst mid-scan with a value pending:
   - an = 0000, dec = 0, pending = 0, frame_done = 0 without waiting for a clock.
   - After release the scan restarts at digit 0 showing 0.
6. LEAD_ZERO_BLANK_EN defined:
   - Load 16'h0042 -> digits 3, 2 give dec = F; digits 1, 0 give dec = 4, 2.
   - Load 16'h0000 -> digit 0 gives dec = 0, digits 1..3 give dec = F.
   - Load 16'h1003 -> no digits are blanked.
